// File: rtl/op_drain_pkg.sv
// Shared constants and FSM encoding for the OP_SRAM drain path.
// Optional feature macro (used by op_sram_drain): OP_DRAIN_CKSUM_EN.
package op_drain_pkg;

    localparam int OP_DEPTH   = 16;
    localparam int OP_ADDR_W  = 4;
    localparam int OP_ROW_W   = 128;
    localparam int OP_BEAT_W  = 32;
    localparam int BEATS      = OP_ROW_W / OP_BEAT_W;
    localparam int BEAT_CNT_W = $clog2(BEATS);

    // Drain FSM encoding, kept as plain constants for legacy tooling.
    typedef logic [2:0] state_t;
    localparam state_t IDLE = 3'd0;
    localparam state_t RD   = 3'd1;
    localparam state_t WAIT = 3'd2;
    localparam state_t SEND = 3'd3;
    localparam state_t FIN  = 3'd4;

endpackage

// File: rtl/op_sram_drain_row_serializer.sv
// Holds one OP_SRAM row and streams it out as BEAT_W-bit beats, LSBs first.
// A new row is loaded with load; row_done flags the handshake of its last beat.
module row_serializer
    import op_drain_pkg::*;
#(
    parameter int ROW_W  = OP_ROW_W,
    parameter int BEAT_W = OP_BEAT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ROW_W-1:0]  row_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [BEAT_W-1:0] out_data,
    output logic              beat_last,
    output logic              row_done
);

    localparam int NBEATS = ROW_W / BEAT_W;
    localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic [ROW_W-1:0] row_buf;
    logic [BCW-1:0]   beat;
    logic             vld;

    // Capture a row, then step through its beats on each accepted handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_buf <= '0;
            beat    <= '0;
            vld     <= 1'b0;
        end else if (load) begin
            row_buf <= row_in;
            beat    <= '0;
            vld     <= 1'b1;
        end else if (vld && out_ready) begin
            if (beat_last) begin
                beat <= '0;
                vld  <= 1'b0;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Beat select and last-beat handshake detection; valid is never a function of ready.
    always_comb begin
        beat_last = (beat == BCW'(NBEATS - 1));
        out_valid = vld;
        out_data  = row_buf[int'(beat) * BEAT_W +: BEAT_W];
        row_done  = vld && out_ready && beat_last;
    end

endmodule

// File: rtl/op_sram_drain.sv
// Drains num_rows rows of OP_SRAM from address 0 onto a valid/ready beat stream.
// Define OP_DRAIN_CKSUM_EN to add the cksum output (XOR of all accepted beats).
module op_sram_drain
    import op_drain_pkg::*;
#(
    parameter int DEPTH  = OP_DEPTH,
    parameter int ADDR_W = OP_ADDR_W,
    parameter int ROW_W  = OP_ROW_W,
    parameter int BEAT_W = OP_BEAT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_rows,
    output logic              busy,
    output logic              done,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [ROW_W-1:0]  sram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last
`ifdef OP_DRAIN_CKSUM_EN
    ,
    output logic [BEAT_W-1:0] cksum
`endif
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic              accept_q;
    logic [ADDR_W:0]   n;
    logic [ADDR_W:0]   n_req;
    logic [ADDR_W-1:0] row;
    logic              start_acc;
    logic              last_row;
    logic              load;
    logic              beat_last;
    logic              row_done;

    // Start acceptance, row-count clamp and last-row detection.
    always_comb begin
        start_acc = start && (state == IDLE) && !accept_q;
        n_req     = (num_rows > DEPTH_L) ? DEPTH_L : num_rows;
        last_row  = ({1'b0, row} == (n - 1'b1));
        load      = (state == WAIT);
    end

    // Drain sequencing: the accepted start is registered once, then one RD/WAIT/SEND pass per row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            accept_q <= 1'b0;
            n        <= '0;
            row      <= '0;
        end else begin
            accept_q <= start_acc;
            if (start_acc) begin
                n   <= n_req;
                row <= '0;
            end
            case (state)
                IDLE: if (accept_q) state <= (n == '0) ? FIN : RD;
                RD:   state <= WAIT;
                WAIT: state <= SEND;
                SEND: begin
                    if (row_done) begin
                        if (last_row) begin
                            state <= FIN;
                        end else begin
                            row   <= row + 1'b1;
                            state <= RD;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM strobes and status decoded straight from state so reset takes effect immediately.
    always_comb begin
        busy      = (state != IDLE) || accept_q;
        done      = (state == FIN);
        sram_cen  = (state != RD);
        sram_wen  = 1'b1;
        sram_addr = row;
        out_last  = out_valid && beat_last && last_row;
    end

    row_serializer #(
        .ROW_W  (ROW_W),
        .BEAT_W (BEAT_W)
    ) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .row_in    (sram_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .beat_last (beat_last),
        .row_done  (row_done)
    );

`ifdef OP_DRAIN_CKSUM_EN
    // Running XOR of accepted beats, restarted on each accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cksum <= '0;
        end else if (start_acc) begin
            cksum <= '0;
        end else if (out_valid && out_ready) begin
            cksum <= cksum ^ out_data;
        end
    end
`endif

endmodule

// File: tb/tb_op_sram_drain.sv
// Bench for op_sram_drain: OP_SRAM model with 1-cycle read latency, queue-based
// beat model, per-cycle stream checks and directed drains.
module tb_op_sram_drain;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int ROW_W  = 128;
    localparam int BEAT_W = 32;
    localparam int BEATS  = ROW_W / BEAT_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_rows = '0;
    logic              busy, done, sram_cen, sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [ROW_W-1:0]  sram_q = '0;
    logic              out_valid, out_last;
    logic              out_ready = 1'b1;
    logic [BEAT_W-1:0] out_data;
`ifdef OP_DRAIN_CKSUM_EN
    logic [BEAT_W-1:0] cksum;
    logic [BEAT_W-1:0] cks_done = '0;
`endif

    op_sram_drain dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_q    (sram_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef OP_DRAIN_CKSUM_EN
        ,
        .cksum     (cksum)
`endif
    );

    always #5 clk = ~clk;

    // OP_SRAM model: registered read, one cycle latency.
    logic [ROW_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_cen) sram_q <= mem[sram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: expected beats of the current drain plus observation counters.
    logic [BEAT_W-1:0] exp_q [$];
    logic [BEAT_W-1:0] got [$];
    int                addr_q [$];
    int                beats = 0, cen_cnt = 0, done_cnt = 0, wen_bad = 0;
    bit                rnd_ready = 1'b0;
    bit                prev_stall = 1'b0, prev_last_hs = 1'b0;
    logic [BEAT_W-1:0] prev_data = '0;
    logic              prev_lastv = 1'b0;

    // Sink ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: every cycle, against the beat model and the stream rules.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (!sram_cen) begin
                cen_cnt++;
                addr_q.push_back(int'(sram_addr));
            end
            if (!sram_wen) wen_bad++;
            if (done) done_cnt++;
`ifdef OP_DRAIN_CKSUM_EN
            if (done) cks_done = cksum;
`endif
            if (prev_last_hs) check("done_after_last", done, 1'b1);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_lastv);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", out_valid, 1'b0);
                end else begin
                    check("beat_data", out_data, exp_q[0]);
                    check("beat_last", out_last, exp_q.size() == 1);
                    if (out_ready) begin
                        got.push_back(out_data);
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end else if (out_last) begin
                check("last_no_valid", out_last, 1'b0);
            end
            prev_stall   = out_valid && !out_ready;
            prev_data    = out_data;
            prev_lastv   = out_last;
            prev_last_hs = out_valid && out_ready && out_last;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_cen"}, sram_cen, 1'b1);
        check({tag, "_wen"}, sram_wen, 1'b1);
        check({tag, "_addr"}, sram_addr, '0);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_data"}, out_data, '0);
        check({tag, "_last"}, out_last, 1'b0);
`ifdef OP_DRAIN_CKSUM_EN
        check({tag, "_cksum"}, cksum, '0);
`endif
    endtask

    task automatic fill_incr();
        for (int r = 0; r < DEPTH; r++) mem[r] = {16{8'(r)}};
    endtask

    // One drain: nr requested rows; optional second start / reset at a given beat count;
    // done_k > 0 pins the cycle (after the start-sampling edge) at which done appears.
    task automatic run_drain(input int nr, input bit rnd, input int second_at,
                             input int reset_at, input int done_k);
        int  n;
        int  k;
        bit  seen;
        bit  sent2;
        bit  ok;
        n = (nr > DEPTH) ? DEPTH : nr;
        sent2 = 1'b0;
        exp_q.delete(); got.delete(); addr_q.delete();
        beats = 0; cen_cnt = 0; done_cnt = 0; wen_bad = 0;
        for (int r = 0; r < n; r++)
            for (int b = 0; b < BEATS; b++)
                exp_q.push_back(mem[r][b*BEAT_W +: BEAT_W]);
        rnd_ready = rnd;
        @(posedge clk); #2;
        start = 1'b1;
        num_rows = (ADDR_W + 1)'(nr);
        @(posedge clk); #2;
        start = 1'b0;
        num_rows = '0;
        @(negedge clk); #2;
        check("k1_busy", busy, 1'b1);
        check("k1_cen", sram_cen, 1'b1);
        check("k1_done", done, 1'b0);
        @(negedge clk); #2;
        if (n == 0) begin
            check("k2_done_zero", done, 1'b1);
            check("k2_cen_zero", sram_cen, 1'b1);
            k = 2;
            seen = 1'b1;
        end else begin
            check("k2_cen", sram_cen, 1'b0);
            check("k2_addr", sram_addr, '0);
            @(negedge clk); #2;
            check("k3_cen", sram_cen, 1'b1);
            check("k3_valid", out_valid, 1'b0);
            @(negedge clk); #2;
            check("k4_valid", out_valid, 1'b1);
            k = 4;
            seen = 1'b0;
        end
        while (!seen && k < 3000) begin
            @(negedge clk); #2;
            k++;
            if (second_at >= 0 && !sent2 && beats == second_at) begin
                start = 1'b1;
                num_rows = 5'd3;
                sent2 = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (reset_at >= 0 && beats == reset_at) begin
                reset_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
                exp_q.delete();
                repeat (2) @(negedge clk);
                #2;
                reset_n = 1'b1;
                repeat (2) @(negedge clk);
                check("midrst_no_done", done_cnt, 0);
                check("midrst_beats", beats, reset_at);
                return;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 1'b0, 1'b1);
        else if (done_k > 0) check("done_cycle", k, done_k);
        repeat (3) @(negedge clk);
        #2;
        check("beat_count", beats, n * BEATS);
        check("done_pulses", done_cnt, 1);
        check("cen_cycles", cen_cnt, n);
        check("model_empty", exp_q.size(), 0);
        check("busy_after", busy, 1'b0);
        check("wen_never_low", wen_bad, 0);
        ok = (addr_q.size() == n);
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) ok = 1'b0;
        check("addr_seq", ok, 1'b1);
    endtask

    initial begin
        fill_incr();
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Incrementing rows, full throughput.
        run_drain(16, 1'b0, -1, -1, 98);
        check("beat0_lit", got[0], 32'h0000_0000);
        check("beat21_lit", got[21], 32'h0505_0505);
        check("beat63_lit", got[63], 32'h0f0f_0f0f);
`ifdef OP_DRAIN_CKSUM_EN
        check("cksum_incr", cks_done, 32'h0000_0000);
`endif

        // Same rows, random back-pressure.
        run_drain(16, 1'b1, -1, -1, 0);
        check("rnd_beat22_lit", got[22], 32'h0505_0505);

        // Zero rows: no SRAM access, single done.
        run_drain(0, 1'b0, -1, -1, 0);

        // Oversized request clamps to DEPTH.
        run_drain(20, 1'b0, -1, -1, 98);

        // Start while busy is ignored.
        run_drain(16, 1'b1, 10, -1, 0);

        // Reset mid-drain, then a fresh drain from address 0.
        run_drain(16, 1'b0, -1, 30, 0);
        run_drain(16, 1'b0, -1, -1, 98);

        // Random row contents, short drain with back-pressure.
        for (int r = 0; r < DEPTH; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};
        run_drain(3, 1'b1, -1, -1, 0);
        fill_incr();

`ifdef OP_DRAIN_CKSUM_EN
        // Single-row checksum, held after done.
        mem[0] = 128'h1;
        run_drain(1, 1'b0, -1, -1, 0);
        check("cksum_one", cks_done, 32'h0000_0001);
        check("cksum_hold", cksum, 32'h0000_0001);
        fill_incr();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

endmodule
